// File: rtl/sysmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sysmem_arbiter_if
//  Description : Bundles the two native-interface requester ports and the
//                single-port system RAM port of the system memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sysmem_arbiter_if #(
    parameter int ADDR_W = 10
);
    // Requester 0 (CPU)
    logic              m0_valid;
    logic [31:0]       m0_addr;
    logic [31:0]       m0_wdata;
    logic [3:0]        m0_wstrb;
    logic              m0_ready;
    logic [31:0]       m0_rdata;

    // Requester 1 (DMA / debug)
    logic              m1_valid;
    logic [31:0]       m1_addr;
    logic [31:0]       m1_wdata;
    logic [3:0]        m1_wstrb;
    logic              m1_ready;
    logic [31:0]       m1_rdata;

    // RAM port
    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_we;
    logic [31:0]       ram_rdata;

    // Status
    logic              busy;

    // Arbiter side
    modport slave (
        input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
        output m0_ready, m0_rdata,
        input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
        output m1_ready, m1_rdata,
        output ram_en, ram_addr, ram_wdata, ram_we,
        input  ram_rdata,
        output busy
    );

    // Environment side (requesters plus RAM)
    modport master (
        output m0_valid, m0_addr, m0_wdata, m0_wstrb,
        input  m0_ready, m0_rdata,
        output m1_valid, m1_addr, m1_wdata, m1_wstrb,
        input  m1_ready, m1_rdata,
        input  ram_en, ram_addr, ram_wdata, ram_we,
        output ram_rdata,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/sysmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sysmem_arbiter
//  Description : Round-robin arbiter/sequencer putting two valid/ready
//                requesters onto one single-port synchronous RAM with a
//                1-cycle read latency. One transaction per grant, 4 cycles
//                per transaction; out-of-range addresses never touch the RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module sysmem_arbiter #(
    parameter int ADDR_W = 10
) (
    input  wire logic         clk,
    input  wire logic         resetn,
    sysmem_arbiter_if.slave   bus
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_RESP   = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    logic [1:0]  state_q,    state_d;
    logic        last_gnt_q, last_gnt_d;
    logic        gnt_q,      gnt_d;
    logic [31:2] addr_q,     addr_d;     // byte-lane bits are never needed
    logic [31:0] wdata_q,    wdata_d;
    logic [3:0]  wstrb_q,    wstrb_d;
    logic [31:0] rdata_q,    rdata_d;

    logic        w_winner;
    logic        w_in_range;

    // Byte-offset address bits carry no information for a word RAM.
    wire w_unused = &{1'b0, bus.m0_addr[1:0], bus.m1_addr[1:0]};

    // Addresses beyond the RAM complete as no-ops.
    assign w_in_range = (addr_q[31:ADDR_W+2] == '0);

    // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        if (bus.m0_valid && bus.m1_valid) begin
            w_winner = ~last_gnt_q;
        end else begin
            w_winner = bus.m1_valid;
        end
    end

    // Next-state and request-latch logic; requester inputs are only looked at in IDLE.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = gnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        case (state_q)
            c_IDLE: begin
                if (bus.m0_valid || bus.m1_valid) begin
                    gnt_d      = w_winner;
                    last_gnt_d = w_winner;
                    addr_d     = w_winner ? bus.m1_addr[31:2] : bus.m0_addr[31:2];
                    wdata_d    = w_winner ? bus.m1_wdata      : bus.m0_wdata;
                    wstrb_d    = w_winner ? bus.m1_wstrb      : bus.m0_wstrb;
                    state_d    = c_ACCESS;
                end
            end
            c_ACCESS: begin
                state_d = c_RESP;
            end
            c_RESP: begin
                rdata_d = (w_in_range && (wstrb_q == 4'b0000)) ? bus.ram_rdata : 32'h0;
                state_d = c_DONE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // State and request registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= c_IDLE;
            last_gnt_q <= 1'b1;
            gnt_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rdata_q    <= rdata_d;
        end
    end

    // RAM port is driven only during ACCESS and is quiet otherwise.
    always_comb begin
        bus.ram_en    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        bus.ram_we    = 4'b0000;
        if (state_q == c_ACCESS) begin
            bus.ram_en    = w_in_range;
            bus.ram_addr  = addr_q[ADDR_W+1:2];
            bus.ram_wdata = wdata_q;
            bus.ram_we    = w_in_range ? wstrb_q : 4'b0000;
        end
    end

    // Completion pulse goes to the granted requester only; both see the read data.
    always_comb begin
        bus.m0_ready = (state_q == c_DONE) && !gnt_q;
        bus.m1_ready = (state_q == c_DONE) &&  gnt_q;
        bus.m0_rdata = rdata_q;
        bus.m1_rdata = rdata_q;
        bus.busy     = (state_q != c_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_sysmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sysmem_arbiter
//  Description : Directed self-checking bench for sysmem_arbiter with a
//                behavioural 1-cycle-latency byte-writable RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sysmem_arbiter;

    localparam int ADDR_W = 10;

    logic clk;
    logic resetn;
    int   n_chk;
    int   n_pass;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    sysmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    sysmem_arbiter #(.ADDR_W(ADDR_W)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM, read-before-write, per-byte enables
    always @(posedge clk) begin
        if (bus.ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.ram_we[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
            end
            bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit id, input logic v, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
        if (!id) begin
            bus.m0_valid = v; bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_wstrb = wstrb;
        end else begin
            bus.m1_valid = v; bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_wstrb = wstrb;
        end
    endtask

    // One isolated transaction, checked cycle by cycle from IDLE (N) to N+4.
    task automatic txn(input string tag, input bit id, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb,
                       input logic exp_en, input logic [31:0] exp_raddr,
                       input logic [3:0] exp_we, input logic [31:0] exp_rdata);
        @(posedge clk); #1;
        drive(id, 1'b1, addr, wdata, wstrb);
        @(negedge clk);                                   // N
        chk({tag, ".idle_en"},  {31'b0, bus.ram_en}, 32'h0);
        @(negedge clk);                                   // N+1
        chk({tag, ".en"},       {31'b0, bus.ram_en}, {31'b0, exp_en});
        chk({tag, ".raddr"},    {22'b0, bus.ram_addr}, exp_raddr);
        chk({tag, ".we"},       {28'b0, bus.ram_we}, {28'b0, exp_we});
        chk({tag, ".wdata"},    bus.ram_wdata, wdata);
        chk({tag, ".busy"},     {31'b0, bus.busy}, 32'h1);
        @(negedge clk);                                   // N+2
        chk({tag, ".rdy_early"}, {30'b0, bus.m1_ready, bus.m0_ready}, 32'h0);
        chk({tag, ".en_off"},   {31'b0, bus.ram_en}, 32'h0);
        @(negedge clk);                                   // N+3
        chk({tag, ".rdy"},      {30'b0, bus.m1_ready, bus.m0_ready}, id ? 32'h2 : 32'h1);
        chk({tag, ".rdata0"},   bus.m0_rdata, exp_rdata);
        chk({tag, ".rdata1"},   bus.m1_rdata, exp_rdata);
        @(posedge clk); #1;
        drive(id, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);                                   // N+4
        chk({tag, ".rdy_late"}, {30'b0, bus.m1_ready, bus.m0_ready}, 32'h0);
        chk({tag, ".idle"},     {31'b0, bus.busy}, 32'h0);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
        mem[0] = 32'hA5A5A5A5;
        mem[5] = 32'hDEADBEEF;
        mem[8] = 32'h11223344;
        bus.ram_rdata = 32'h0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        resetn = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.busy",  {31'b0, bus.busy}, 32'h0);
        chk("rst.en",    {31'b0, bus.ram_en}, 32'h0);
        chk("rst.we",    {28'b0, bus.ram_we}, 32'h0);
        chk("rst.rdy",   {30'b0, bus.m1_ready, bus.m0_ready}, 32'h0);
        chk("rst.rdata", bus.m0_rdata, 32'h0);

        // Both valid from reset release: m0, m1, m0, m1 with ready 4 cycles apart
        @(posedge clk); #1;
        resetn = 1'b1;
        drive(1'b0, 1'b1, 32'h14, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 32'h20, 32'h0, 4'h0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk($sformatf("rr.m0_rdy[%0d]", k), {31'b0, bus.m0_ready}, (k == 3 || k == 11) ? 32'h1 : 32'h0);
            chk($sformatf("rr.m1_rdy[%0d]", k), {31'b0, bus.m1_ready}, (k == 7 || k == 15) ? 32'h1 : 32'h0);
            if (k == 3 || k == 11) chk($sformatf("rr.rd0[%0d]", k), bus.m0_rdata, 32'hDEADBEEF);
            if (k == 7 || k == 15) chk($sformatf("rr.rd1[%0d]", k), bus.m1_rdata, 32'h11223344);
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("rr.idle", {31'b0, bus.busy}, 32'h0);

        // Directed single transactions
        txn("rd5",   1'b0, 32'h14, 32'h0, 4'b0000, 1'b1, 32'd5, 4'b0000, 32'hDEADBEEF);
        txn("wrb1",  1'b1, 32'h20, 32'h0000AB00, 4'b0010, 1'b1, 32'd8, 4'b0010, 32'h0);
        txn("rd8",   1'b0, 32'h20, 32'h0, 4'b0000, 1'b1, 32'd8, 4'b0000, 32'h1122AB44);
        txn("oorwr", 1'b0, 32'h0000_1000, 32'hFFFFFFFF, 4'b1111, 1'b0, 32'd0, 4'b0000, 32'h0);
        chk("oorwr.mem0", mem[0], 32'hA5A5A5A5);
        txn("rd0",   1'b0, 32'h0, 32'h0, 4'b0000, 1'b1, 32'd0, 4'b0000, 32'hA5A5A5A5);
        txn("oorrd", 1'b1, 32'hFFFF_FFFC, 32'h0, 4'b0000, 1'b0, 32'h3FF, 4'b0000, 32'h0);

        // Reset asserted during ACCESS of an m1 write
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 32'h24, 32'h12345678, 4'b1111);
        @(negedge clk);
        @(negedge clk);
        chk("rstmid.we_pre",   {28'b0, bus.ram_we}, 32'hF);
        chk("rstmid.busy_pre", {31'b0, bus.busy}, 32'h1);
        #1 resetn = 1'b0;
        #1;
        chk("rstmid.we",   {28'b0, bus.ram_we}, 32'h0);
        chk("rstmid.en",   {31'b0, bus.ram_en}, 32'h0);
        chk("rstmid.busy", {31'b0, bus.busy}, 32'h0);
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rstmid.m1_rdy[%0d]", k), {31'b0, bus.m1_ready}, 32'h0);
        end

        // After release a tie goes to m0 first, then m1
        @(posedge clk); #1;
        resetn = 1'b1;
        drive(1'b0, 1'b1, 32'h14, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 32'h20, 32'h0, 4'h0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("post.m0_rdy[%0d]", k), {31'b0, bus.m0_ready}, (k == 3) ? 32'h1 : 32'h0);
            chk($sformatf("post.m1_rdy[%0d]", k), {31'b0, bus.m1_ready}, (k == 7) ? 32'h1 : 32'h0);
            if (k == 3) begin
                chk("post.rd0", bus.m0_rdata, 32'hDEADBEEF);
                drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            end
            if (k == 7) begin
                chk("post.rd1", bus.m1_rdata, 32'h1122AB44);
                drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
            end
        end
        @(negedge clk);
        chk("post.idle", {31'b0, bus.busy}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
